sms_timing_ring_ctrl: RTL and testbench

Sequences the free-running 1 MHz oscillator card output into the 1620 memory-cycle timing gates T0..T(NUM_T-1), one-hot, one gate per OSC_PER_T oscillator pulses. It is the run, stop and single-cycle controller between the oscillator card and the timing-gate consumers: memory, adder and console logic. Cycles always start aligned to an oscillator edge and are never truncated except by reset.

---
 rtl/sms_timing_pkg.sv | 24 ++
 rtl/sms_osc_edge_sync.sv | 29 ++
 rtl/sms_timing_ring_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sms_timing_ring_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sms_timing_pkg.sv
// Shared types and defaults for the 1620 memory-cycle timing ring.
// Holds the controller state/mode encodings and the default ring geometry.
package sms_timing_pkg;

    localparam int NUM_T_DEF     = 10;
    localparam int OSC_PER_T_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_CONT   = 1'b0,
        MODE_SINGLE = 1'b1
    } mode_t;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sms_osc_edge_sync.sv
// Oscillator card input conditioner: 2-flop synchronizer plus rising-edge
// detect. osc_rise is a one-clk pulse per oscillator rising edge, osc_lvl the
// synchronized level. Usable by any consumer of the oscillator card output.
module sms_osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic osc,
    output logic osc_rise,
    output logic osc_lvl
);

    logic s1;
    logic s2;

    // Two-stage synchronizer for the asynchronous oscillator input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= osc;
            s2 <= s1;
        end
    end

    assign osc_rise = s1 & ~s2;
    assign osc_lvl  = s2;

endmodule

// File: rtl/sms_timing_ring_ctrl.sv
// Run/stop/single-cycle controller that turns oscillator edges into the
// one-hot memory-cycle timing gates T0..T(NUM_T-1).
// Optional oscillator-loss watchdog: define TAF_OSC_WATCHDOG_EN to enable it;
// without it osc_fail is tied low and a stalled oscillator simply holds the
// controller in ARM or RUN.
module sms_timing_ring_ctrl
    import sms_timing_pkg::*;
#(
    parameter int NUM_T     = NUM_T_DEF,
    parameter int OSC_PER_T = OSC_PER_T_DEF
`ifdef TAF_OSC_WATCHDOG_EN
    ,
    parameter int WD_LIMIT  = 256
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     osc,
    input  logic                     run_req,
    input  logic                     stop_req,
    input  logic                     step_req,
    output logic [NUM_T-1:0]         t_gate,
    output logic [$clog2(NUM_T)-1:0] t_index,
    output logic                     cycle_start,
    output logic                     cycle_end,
    output logic                     running,
    output logic                     osc_fail
);

    localparam int TW = cnt_w(NUM_T);
    localparam int SW = cnt_w(OSC_PER_T);
    localparam logic [TW-1:0] T_LAST   = TW'(NUM_T - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(OSC_PER_T - 1);

    logic          osc_rise;
    logic          osc_lvl_unused;

    state_t        state;
    state_t        state_nxt;
    mode_t         mode;
    mode_t         mode_nxt;
    logic [SW-1:0] sub;
    logic [SW-1:0] sub_nxt;
    logic [TW-1:0] t;
    logic [TW-1:0] t_nxt;
    logic          stop_pend;
    logic          stop_pend_nxt;
    logic          cs_q;
    logic          cs_nxt;
    logic          ce_q;
    logic          ce_nxt;
    logic          start_ok;

`ifdef TAF_OSC_WATCHDOG_EN
    localparam int WW = $clog2(WD_LIMIT + 1);
    logic [WW-1:0] wd_cnt;
    logic [WW-1:0] wd_cnt_nxt;
    logic          fail_q;
    logic          fail_nxt;

    // A lost oscillator locks out new starts until reset.
    assign start_ok = ~fail_q;
    assign osc_fail = fail_q;
`else
    assign start_ok = 1'b1;
    assign osc_fail = 1'b0;
`endif

    sms_osc_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .osc      (osc),
        .osc_rise (osc_rise),
        .osc_lvl  (osc_lvl_unused)
    );

    // State register: FSM state, ring counters, stop latch and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode      <= MODE_CONT;
            sub       <= '0;
            t         <= '0;
            stop_pend <= 1'b0;
            cs_q      <= 1'b0;
            ce_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode      <= mode_nxt;
            sub       <= sub_nxt;
            t         <= t_nxt;
            stop_pend <= stop_pend_nxt;
            cs_q      <= cs_nxt;
            ce_q      <= ce_nxt;
        end
    end

`ifdef TAF_OSC_WATCHDOG_EN
    // Watchdog register: clks since the last oscillator edge and sticky fail flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            fail_q <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_nxt;
            fail_q <= fail_nxt;
        end
    end
`endif

    // Next-state logic: start arbitration, gate advance and cycle-boundary decisions.
    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode;
        sub_nxt       = sub;
        t_nxt         = t;
        stop_pend_nxt = stop_pend;
        cs_nxt        = 1'b0;
        ce_nxt        = 1'b0;

        case (state)
            ST_IDLE: begin
                sub_nxt       = '0;
                t_nxt         = '0;
                stop_pend_nxt = 1'b0;
                // run_req outranks step_req when both arrive together.
                if (start_ok) begin
                    if (run_req) begin
                        state_nxt = ST_ARM;
                        mode_nxt  = MODE_CONT;
                    end else if (step_req) begin
                        state_nxt = ST_ARM;
                        mode_nxt  = MODE_SINGLE;
                    end
                end
            end

            ST_ARM: begin
                // A stop while armed abandons the start; no partial cycle.
                if (stop_req || stop_pend) begin
                    state_nxt     = ST_IDLE;
                    stop_pend_nxt = 1'b0;
                end else if (osc_rise) begin
                    state_nxt = ST_RUN;
                    sub_nxt   = '0;
                    t_nxt     = '0;
                    cs_nxt    = 1'b1;
                end
            end

            ST_RUN: begin
                if (stop_req) begin
                    stop_pend_nxt = 1'b1;
                end
                if (osc_rise) begin
                    if (sub == SUB_LAST) begin
                        sub_nxt = '0;
                        if (t == T_LAST) begin
                            // Cycle boundary: stop here or wrap straight into T0.
                            ce_nxt = 1'b1;
                            t_nxt  = '0;
                            if (mode == MODE_SINGLE || stop_pend_nxt || !run_req) begin
                                state_nxt     = ST_IDLE;
                                stop_pend_nxt = 1'b0;
                            end else begin
                                cs_nxt = 1'b1;
                            end
                        end else begin
                            t_nxt = t + 1'b1;
                        end
                    end else begin
                        sub_nxt = sub + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

`ifdef TAF_OSC_WATCHDOG_EN
        wd_cnt_nxt = '0;
        fail_nxt   = fail_q;
        if ((state == ST_ARM || state == ST_RUN) && !osc_rise) begin
            wd_cnt_nxt = wd_cnt + 1'b1;
            // Oscillator lost: drop the cycle silently, no cycle_end.
            if (wd_cnt_nxt == WW'(WD_LIMIT)) begin
                wd_cnt_nxt    = '0;
                fail_nxt      = 1'b1;
                state_nxt     = ST_IDLE;
                sub_nxt       = '0;
                t_nxt         = '0;
                stop_pend_nxt = 1'b0;
                cs_nxt        = 1'b0;
                ce_nxt        = 1'b0;
            end
        end
`endif
    end

    // Output decode: one-hot gate and its index only while RUN.
    always_comb begin
        t_gate      = '0;
        t_index     = '0;
        running     = (state != ST_IDLE);
        cycle_start = cs_q;
        cycle_end   = ce_q;
        if (state == ST_RUN) begin
            t_gate[t] = 1'b1;
            t_index   = t;
        end
    end

endmodule

// File: tb/tb_sms_timing_ring_ctrl.sv
// Directed bench for sms_timing_ring_ctrl with a 1 MHz oscillator card model
// and a 100 MHz clk. A negedge monitor tracks gate invariants, pulse counts
// and per-gate durations; the main sequence walks the run/stop/step scenarios.
`timescale 1ns/1ps
module tb_sms_timing_ring_ctrl;

    localparam int NUM_T    = 10;
    localparam int TW       = 4;
    localparam int GATE_CLK = 200;
    localparam int LIMIT    = 10000;

    logic             clk = 1'b0;
    logic             rst;
    logic             osc;
    logic             osc_en;
    logic             run_req;
    logic             stop_req;
    logic             step_req;
    logic [NUM_T-1:0] t_gate;
    logic [TW-1:0]    t_index;
    logic             cycle_start;
    logic             cycle_end;
    logic             running;
    logic             osc_fail;

    int checks  = 0;
    int errors  = 0;
    int n_start = 0;
    int n_end   = 0;
    int inv_bad = 0;
    int run_len = 0;
    int b_start = 0;
    int b_end   = 0;
    int gate_len [NUM_T];
    logic [NUM_T-1:0] prev_gate = '0;

    sms_timing_ring_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .osc         (osc),
        .run_req     (run_req),
        .stop_req    (stop_req),
        .step_req    (step_req),
        .t_gate      (t_gate),
        .t_index     (t_index),
        .cycle_start (cycle_start),
        .cycle_end   (cycle_end),
        .running     (running),
        .osc_fail    (osc_fail)
    );

    always #5 clk = ~clk;

    // Oscillator card: 1 MHz, rising edges 1000 ns apart, held low when disabled.
    initial begin
        osc = 1'b0;
        #2;
        forever begin
            #500;
            osc = osc_en ? ~osc : 1'b0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every clk: one-hot/index consistency, wrap coincidence, pulse counts, gate lengths.
    always @(negedge clk) begin
        int pos;
        pos = 0;
        for (int k = 0; k < NUM_T; k++) if (t_gate[k]) pos = k;
        if (t_gate != '0 && (!$onehot(t_gate) || int'(t_index) != pos)) inv_bad++;
        if (t_gate == '0 && t_index != '0) inv_bad++;
        if (!running && t_gate != '0) inv_bad++;
        if (cycle_start && t_gate != NUM_T'(1)) inv_bad++;
        if (cycle_end && (cycle_start != t_gate[0])) inv_bad++;
        if (cycle_start) n_start++;
        if (cycle_end) n_end++;
        if (t_gate == prev_gate) begin
            run_len++;
        end else begin
            for (int k = 0; k < NUM_T; k++) if (prev_gate[k]) gate_len[k] = run_len;
            run_len = 1;
        end
        prev_gate = t_gate;
    end

    task automatic wait_gate(input string tag, input int cyc, input int idx);
        int guard;
        guard = 0;
        while (!((n_start - b_start) == cyc && int'(t_index) == idx && t_gate != '0)
               && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk(tag, int'(guard < LIMIT), 1);
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (running && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk(tag, int'(guard < LIMIT), 1);
    endtask

    initial begin
        rst      = 1'b1;
        run_req  = 1'b0;
        stop_req = 1'b0;
        step_req = 1'b0;
        osc_en   = 1'b1;
        for (int k = 0; k < NUM_T; k++) gate_len[k] = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_t_gate", int'(t_gate), 0);
        chk("rst_t_index", int'(t_index), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_cycle_start", int'(cycle_start), 0);
        chk("rst_cycle_end", int'(cycle_end), 0);
        chk("rst_osc_fail", int'(osc_fail), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Scenario 1: single step gives exactly one 20 us cycle
        b_start = n_start;
        b_end   = n_end;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        chk("s1_armed", int'(running), 1);
        wait_idle("s1_idle_timeout");
        chk("s1_starts", n_start - b_start, 1);
        chk("s1_ends", n_end - b_end, 1);
        chk("s1_t_gate_idle", int'(t_gate), 0);
        for (int k = 0; k < NUM_T; k++)
            chk($sformatf("s1_len_T%0d", k), gate_len[k], GATE_CLK);
        repeat (300) @(negedge clk);
        chk("s1_no_restart", n_start - b_start, 1);
        chk("s1_invariant", inv_bad, 0);

        // Scenario 2: continuous run, stray step ignored, stop in T4 of cycle 3
        b_start = n_start;
        b_end   = n_end;
        run_req = 1'b1;
        wait_gate("s2_c1t3_timeout", 1, 3);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        wait_gate("s2_c3t4_timeout", 3, 4);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        wait_idle("s2_idle_timeout");
        run_req = 1'b0;
        chk("s2_starts", n_start - b_start, 3);
        chk("s2_ends", n_end - b_end, 3);
        chk("s2_t_gate_idle", int'(t_gate), 0);
        repeat (300) @(negedge clk);
        chk("s2_no_4th_t0", n_start - b_start, 3);
        chk("s2_stays_idle", int'(running), 0);
        chk("s2_invariant", inv_bad, 0);

        // Scenario 3: run+step together picks continuous; drop run in T2 of cycle 2
        b_start = n_start;
        b_end   = n_end;
        run_req  = 1'b1;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        wait_gate("s3_c2t2_timeout", 2, 2);
        run_req = 1'b0;
        wait_idle("s3_idle_timeout");
        chk("s3_starts", n_start - b_start, 2);
        chk("s3_ends", n_end - b_end, 2);
        chk("s3_invariant", inv_bad, 0);

        // Scenario 4: reset during T6 clears everything without cycle_end
        b_start = n_start;
        b_end   = n_end;
        run_req = 1'b1;
        wait_gate("s4_c1t6_timeout", 1, 6);
        rst = 1'b1;
        @(negedge clk);
        chk("s4_t_gate", int'(t_gate), 0);
        chk("s4_t_index", int'(t_index), 0);
        chk("s4_running", int'(running), 0);
        chk("s4_cycle_end", int'(cycle_end), 0);
        run_req = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("s4_no_end_pulse", n_end - b_end, 0);
        chk("s4_invariant", inv_bad, 0);

        // Scenario 6: oscillator stalled low with run_req held
        osc_en = 1'b0;
        repeat (150) @(negedge clk);
        run_req = 1'b1;
        repeat (250) @(negedge clk);
        chk("s6_early_osc_fail", int'(osc_fail), 0);
        chk("s6_early_running", int'(running), 1);
        repeat (50) @(negedge clk);
`ifdef TAF_OSC_WATCHDOG_EN
        chk("s6_osc_fail", int'(osc_fail), 1);
        chk("s6_forced_idle", int'(running), 0);
        chk("s6_t_gate", int'(t_gate), 0);
        repeat (20) @(negedge clk);
        chk("s6_run_locked_out", int'(running), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_clears_fail", int'(osc_fail), 0);
        rst = 1'b0;
        run_req = 1'b0;
`else
        chk("s6_osc_fail_tied", int'(osc_fail), 0);
        chk("s6_waits_in_arm", int'(running), 1);
        chk("s6_t_gate_arm", int'(t_gate), 0);
        run_req = 1'b0;
`endif
        chk("s6_invariant", inv_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
